// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the 9-bit CPU program sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam int D_DEF         = 12;
    localparam int LUT_AW_DEF    = 3;
    localparam int HALT_ADDR_DEF = 460;

endpackage

// File: rtl/branch_lut.sv
// Writable absolute branch-target table: async clear, sync write, comb read.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int D      = D_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [LUT_AW-1:0] waddr_i,
    input  logic [D-1:0]      wdata_i,
    input  logic [LUT_AW-1:0] raddr_i,
    output logic [D-1:0]      rdata_o
);

    logic [D-1:0] mem_q [2**LUT_AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**LUT_AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write value when write and read share an index.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, run-control FSM, branch LUT and executed-cycle counter.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int D          = D_DEF,
    parameter int LUT_AW     = LUT_AW_DEF,
    parameter int START_ADDR = 0,
    parameter int HALT_ADDR  = HALT_ADDR_DEF,
    parameter int CW         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch,
    input  logic              taken,
    input  logic [LUT_AW-1:0] how_high,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    output logic [D-1:0]      prog_ctr,
    output logic              fetch_valid,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     cycle_count
);

    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [D-1:0] HALT_PC  = D'(HALT_ADDR);
    // A halt address wider than the PC can never be reached.
    localparam bit HALT_REACHABLE = (HALT_ADDR >> D) == 0;

    fetch_state_t  state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [D-1:0]  target;
    logic          at_halt;

    branch_lut #(
        .D      (D),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (lut_we),
        .waddr_i (lut_waddr),
        .wdata_i (lut_wdata),
        .raddr_i (how_high),
        .rdata_o (target)
    );

    assign at_halt = HALT_REACHABLE && (pc_q == HALT_PC);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (at_halt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!stall) begin
                    if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (branch && taken) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    done_d  = 1'b0;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign prog_ctr    = pc_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign cycle_count = cnt_q;
    assign fetch_valid = busy && !stall && !at_halt;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Parametrised program sequencer for the 9-bit CPU family. It owns the program counter, the start/done run-control state machine, and a writable branch-target LUT. It also keeps an executed-cycle counter. It replaces the single-cycle PC, PC LUT, next-PC logic and hard-coded done compare. It drives instr_ROM addressing and supports stall, absolute branch via LUT, and a configurable halt address.

Parameters:
D, 12, program counter width
LUT_AW, 3, branch LUT index width (2**LUT_AW entries, each D bits)
START_ADDR, 0, PC value loaded on start
HALT_ADDR, 460, PC value that terminates a run
CW, 16, cycle counter width

Ports:
clk  input  1  system clock
rst_n  input  1  reset
start  input  1  run request pulse
stall  input  1  hold PC this cycle
branch  input  1  current instruction is a branch (from Control)
taken  input  1  branch condition true (from alu)
how_high  input  LUT_AW  LUT index of branch target
lut_we  input  1  LUT write enable
lut_waddr  input  LUT_AW  LUT write index
lut_wdata  input  D  LUT write data (absolute target)
prog_ctr  output  D  current PC to instr_ROM
fetch_valid  output  1  instruction at prog_ctr executes this cycle
busy  output  1  state is RUN
done  output  1  run finished, held until next start
cycle_count  output  CW  executed (non-stalled) cycles of current/last run

Interface decision: one clock, clk; reset rst_n, asynchronous, active-low.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; prog_ctr=START_ADDR; done=0; busy=0; cycle_count=0; all LUT entries=0. fetch_valid=0 follows combinationally.
- States:
  - IDLE: start=1 -> RUN; prog_ctr<=START_ADDR; cycle_count<=0.
  - RUN, halt check: if prog_ctr==HALT_ADDR -> DONE; done<=1; PC held. Halt has priority over stall and branch. The instruction at HALT_ADDR is not executed.
  - RUN, stall: if stall=1 -> PC and cycle_count hold; branch/taken ignored.
  - RUN, taken branch: if branch&&taken -> prog_ctr<=lut[how_high].
  - RUN, default: prog_ctr<=prog_ctr+1, wrapping mod 2**D.
  - RUN, counting: every non-stall, non-halt RUN cycle, cycle_count<=cycle_count+1, saturating at 2**CW-1.
  - DONE: start=1 -> RUN; done<=0; prog_ctr<=START_ADDR; cycle_count<=0. Otherwise hold; cycle_count keeps its final value.
- start while in RUN is ignored (no restart).
- busy = (state==RUN), registered via state.
- fetch_valid = busy && !stall && prog_ctr!=HALT_ADDR (combinational).
- LUT:
  - Synchronous write in any state; visible the cycle after lut_we.
  - Read is combinational.
  - A same-cycle write and branch to the same index uses the old entry.
- Branch target is absolute (D bits), not PC-relative; latency 1 cycle, no delay slot.
- START_ADDR==HALT_ADDR: run enters DONE after one RUN cycle with cycle_count=0.
- Reset asserted mid-run aborts immediately to reset values; LUT contents are lost.

Decomposition:
- Package fetch_pkg: state enum (IDLE, RUN, DONE as 2-bit typedef fetch_state_t) and default constants for D, LUT_AW, HALT_ADDR.
- One sub-module, branch_lut: 2**LUT_AW x D register array with async clear, sync write, combinational read.
- The top-level CPU instantiates fetch_sequencer in place of PC/PC_LUT/nextPC and connects done directly.

Test Plan:
- Reset then start pulse (HALT_ADDR=8): PC steps 0..8 on consecutive cycles; done rises the cycle after PC=8; cycle_count=8; busy falls with done.
- Write lut[3]=40, run, assert branch=taken=1, how_high=3 at PC=2: next PC=40, then 41; cycle_count counts the branch cycle.
- stall held 3 cycles at PC=5: PC stays 5, fetch_valid=0, cycle_count frozen; resumes at 6 when stall drops.
- branch with taken=0 at PC=4: PC=5. branch=taken=1 while stall=1: PC unchanged.
- D=4, HALT_ADDR=20 (unreachable), run: PC wraps 15 -> 0; CW=4 cycle_count saturates at 15.
- rst_n dropped mid-run at PC=7: PC=0, done=0, busy=0 immediately. Start pressed in DONE restarts from START_ADDR with done cleared next cycle.
